// File: rtl/mapreduce_pkg.sv
// Shared definitions for the partition-to-reducer link.
// Holds the collector state encoding, the memory index width, the default
// point type and a small width helper used for source tags.
package mapreduce_pkg;

    localparam int unsigned MEM_INDEX_W       = 16;
    localparam int unsigned DEFAULT_PRECISION = 16;
    localparam int unsigned DEFAULT_DIMENSION = 2;
    localparam int unsigned DEFAULT_POINT_W   = DEFAULT_PRECISION * DEFAULT_DIMENSION;

    // Point payload for the default DIMENSION/PRECISION configuration.
    typedef logic [DEFAULT_POINT_W-1:0] point_t;
    localparam point_t POINT_DEFAULT = '0;

    // Collector state encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACK     = 3'd1,
        ST_GAP     = 3'd2,
        ST_COLLECT = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    // Index width for n entries, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin picker.
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - round-robin pointer; the search starts at this index and wraps
//   grant_c   - one-hot grant (all zero when nothing requests)
//   idx_c     - binary index of the granted requester
//   any_req_c - at least one request bit is high
module rr_arbiter_onehot
    import mapreduce_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_req_c
);

    // Walk priorities from lowest to highest so the closest requester at or
    // above the pointer is the last one written and therefore wins.
    always_comb begin
        grant_c   = '0;
        idx_c     = '0;
        any_req_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            for (int j = 0; j < int'(N); j++) begin
                if (req[j] && (32'(j) == ((32'(ptr) + 32'(i)) % N))) begin
                    grant_c    = '0;
                    grant_c[j] = 1'b1;
                    idx_c      = IDX_W'(j);
                    any_req_c  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reduce_collector.sv
// Reducer-side receiver of the partition-to-reducer link.
// Grants one partitioner at a time (round-robin) with a one-cycle acknowledge,
// captures its memory index and DIMENSION serialized value words, and presents
// the assembled point through a valid/ready output buffer.
// Ports:
//   clock, reset_n      - clock, synchronous active-low reset
//   i_request           - per-partitioner request, held until acknowledged
//   o_acknowledged      - one-hot single-cycle acknowledge
//   i_value_data        - per-partitioner serialized value word
//   i_mem_index         - per-partitioner memory index
//   o_valid / i_ready   - output handshake
//   o_point             - assembled point, word k at [k*PRECISION +: PRECISION]
//   o_mem_index, o_src  - memory index and source partitioner of the point
// Optional (REDUCE_COLLECTOR_PERF_EN defined):
//   o_points_received   - saturating count of transfers into the output buffer
//   o_hold_cycles       - saturating count of cycles spent in HOLD
module reduce_collector
    import mapreduce_pkg::*;
#(
    parameter int unsigned NUM_OF_PARTITIONERS = 4,
    parameter int unsigned PRECISION           = 16,
    parameter int unsigned DIMENSION           = 2,
    parameter int unsigned SRC_W               = clog2_min1(NUM_OF_PARTITIONERS)
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic [NUM_OF_PARTITIONERS-1:0]             i_request,
    output logic [NUM_OF_PARTITIONERS-1:0]             o_acknowledged,
    input  logic [NUM_OF_PARTITIONERS*PRECISION-1:0]   i_value_data,
    input  logic [NUM_OF_PARTITIONERS*MEM_INDEX_W-1:0] i_mem_index,
    output logic                                       o_valid,
    input  logic                                       i_ready,
    output logic [DIMENSION*PRECISION-1:0]             o_point,
    output logic [MEM_INDEX_W-1:0]                     o_mem_index,
    output logic [SRC_W-1:0]                           o_src
`ifdef REDUCE_COLLECTOR_PERF_EN
    ,
    output logic [31:0]                                o_points_received,
    output logic [31:0]                                o_hold_cycles
`endif
);

    localparam int unsigned NP        = NUM_OF_PARTITIONERS;
    localparam int unsigned POINT_W   = DIMENSION * PRECISION;
    localparam int unsigned CNT_W     = $clog2(DIMENSION + 1);
    localparam int unsigned LAST_WORD = DIMENSION - 1;

    state_t                   state_q, state_d;
    logic [SRC_W-1:0]         rr_ptr;
    logic [SRC_W-1:0]         src_q;
    logic [POINT_W-1:0]       asm_point;
    logic [MEM_INDEX_W-1:0]   asm_index;
    logic [CNT_W-1:0]         word_cnt;

    logic [NP-1:0]            arb_grant_c;
    logic [SRC_W-1:0]         arb_idx_c;
    logic                     arb_any_c;
    logic [SRC_W-1:0]         next_ptr_c;

    logic [PRECISION-1:0]     cur_word_c;
    logic [MEM_INDEX_W-1:0]   cur_index_c;
    logic [POINT_W-1:0]       point_merge_c;
    logic                     out_free_c;

    logic [NP-1:0]            ack_d;
    logic                     grant_load_c;
    logic                     index_load_c;
    logic                     word_load_c;
    logic                     transfer_c;
    logic                     xfer_merge_c;

    rr_arbiter_onehot #(
        .N     (NP),
        .IDX_W (SRC_W)
    ) u_arb (
        .req       (i_request),
        .ptr       (rr_ptr),
        .grant_c   (arb_grant_c),
        .idx_c     (arb_idx_c),
        .any_req_c (arb_any_c)
    );

    assign next_ptr_c  = ((32'(arb_idx_c) + 32'd1) == NP) ? '0 : SRC_W'(32'(arb_idx_c) + 32'd1);
    assign cur_word_c  = i_value_data[32'(src_q) * PRECISION +: PRECISION];
    assign cur_index_c = i_mem_index[32'(src_q) * MEM_INDEX_W +: MEM_INDEX_W];
    assign out_free_c  = !o_valid || i_ready;

    // Assembly register with the incoming word already merged in, so the last
    // word can go straight to the output buffer on the same edge.
    always_comb begin
        point_merge_c = asm_point;
        point_merge_c[32'(word_cnt) * PRECISION +: PRECISION] = cur_word_c;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_d      = state_q;
        ack_d        = '0;
        grant_load_c = 1'b0;
        index_load_c = 1'b0;
        word_load_c  = 1'b0;
        transfer_c   = 1'b0;
        xfer_merge_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_c) begin
                    grant_load_c = 1'b1;
                    ack_d        = arb_grant_c;
                    state_d      = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                index_load_c = 1'b1;
                state_d      = ST_COLLECT;
            end
            ST_COLLECT: begin
                word_load_c = 1'b1;
                if (word_cnt == CNT_W'(LAST_WORD)) begin
                    if (out_free_c) begin
                        transfer_c   = 1'b1;
                        xfer_merge_c = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_free_c) begin
                    transfer_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, point assembly and the output buffer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            o_acknowledged <= '0;
            rr_ptr         <= '0;
            src_q          <= '0;
            asm_point      <= '0;
            asm_index      <= '0;
            word_cnt       <= '0;
            o_valid        <= 1'b0;
            o_point        <= '0;
            o_mem_index    <= '0;
            o_src          <= '0;
        end else begin
            o_acknowledged <= ack_d;
            if (grant_load_c) begin
                src_q  <= arb_idx_c;
                rr_ptr <= next_ptr_c;
            end
            if (index_load_c) begin
                asm_index <= cur_index_c;
                word_cnt  <= '0;
            end
            if (word_load_c) begin
                asm_point <= point_merge_c;
                word_cnt  <= word_cnt + CNT_W'(1);
            end
            if (transfer_c) begin
                o_point     <= xfer_merge_c ? point_merge_c : asm_point;
                o_mem_index <= asm_index;
                o_src       <= src_q;
                o_valid     <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef REDUCE_COLLECTOR_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            o_points_received <= '0;
            o_hold_cycles     <= '0;
        end else begin
            if (transfer_c && (o_points_received != 32'hFFFF_FFFF)) begin
                o_points_received <= o_points_received + 32'd1;
            end
            if ((state_q == ST_HOLD) && (o_hold_cycles != 32'hFFFF_FFFF)) begin
                o_hold_cycles <= o_hold_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reduce_collector.sv
// Scoreboard bench for reduce_collector: partitioner models push the expected
// point when acknowledged, a monitor pops and compares on each handshake.
// A second instance (1 partitioner, DIMENSION=1, PRECISION=32) is checked directly.
module tb_reduce_collector;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n = 1'b0;
    logic i_ready = 1'b0;

    wire  [3:0]  req_w;
    wire  [63:0] val_w;
    wire  [63:0] idx_w;
    logic [3:0]  ack;
    logic        valid;
    logic [31:0] point;
    logic [15:0] mem_idx;
    logic [1:0]  src;

    logic        req1   = 1'b0;
    logic [31:0] val1   = '0;
    logic [15:0] idx1   = '0;
    logic        ready1 = 1'b0;
    logic        ack1;
    logic        valid1;
    logic [31:0] point1;
    logic [15:0] midx1;
    logic        src1;

`ifdef REDUCE_COLLECTOR_PERF_EN
    logic [31:0] pts, holds, pts1, holds1;
`endif

    reduce_collector u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .i_request      (req_w),
        .o_acknowledged (ack),
        .i_value_data   (val_w),
        .i_mem_index    (idx_w),
        .o_valid        (valid),
        .i_ready        (i_ready),
        .o_point        (point),
        .o_mem_index    (mem_idx),
        .o_src          (src)
`ifdef REDUCE_COLLECTOR_PERF_EN
        ,
        .o_points_received (pts),
        .o_hold_cycles     (holds)
`endif
    );

    reduce_collector #(
        .NUM_OF_PARTITIONERS (1),
        .PRECISION           (32),
        .DIMENSION           (1)
    ) u_dut1 (
        .clock          (clock),
        .reset_n        (reset_n),
        .i_request      (req1),
        .o_acknowledged (ack1),
        .i_value_data   (val1),
        .i_mem_index    (idx1),
        .o_valid        (valid1),
        .i_ready        (ready1),
        .o_point        (point1),
        .o_mem_index    (midx1),
        .o_src          (src1)
`ifdef REDUCE_COLLECTOR_PERF_EN
        ,
        .o_points_received (pts1),
        .o_hold_cycles     (holds1)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          src;
        logic [15:0] idx;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [31:0] exp_pt;
    } job_t;

    typedef struct {
        logic [31:0] pt;
        logic [15:0] idx;
        logic [1:0]  src;
    } exp_t;

    job_t jobs[$];
    exp_t exp_q[$];
    int   grant_log[$];
    int   released  = 0;
    int   done_jobs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic add_job(input int s, input logic [15:0] ix, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [31:0] exp_pt);
        job_t j;
        j.src = s; j.idx = ix; j.w0 = w0; j.w1 = w1; j.exp_pt = exp_pt;
        jobs.push_back(j);
    endtask

    task automatic release_jobs();
        released = jobs.size();
    endtask

    // Partitioner models: request, wait for ack, then serialize index and words.
    for (genvar p = 0; p < 4; p++) begin : g_part
        logic        req_l = 1'b0;
        logic [15:0] val_l = '0;
        logic [15:0] idx_l = '0;
        int          cur   = 0;
        int          n     = 0;
        exp_t        e;

        assign req_w[p]          = req_l;
        assign val_w[p*16 +: 16] = val_l;
        assign idx_w[p*16 +: 16] = idx_l;

        always begin
            @(negedge clock);
            while (cur < released && jobs[cur].src != p) cur++;
            if (cur < released) begin
                idx_l = jobs[cur].idx;
                req_l = 1'b1;
                n = 0;
                while (!ack[p] && n < 300) begin
                    @(negedge clock);
                    n++;
                end
                check($sformatf("ack_wait_p%0d", p), 64'(n < 300), 64'd1);
                if (n < 300) begin
                    e.pt  = jobs[cur].exp_pt;
                    e.idx = jobs[cur].idx;
                    e.src = 2'(p);
                    exp_q.push_back(e);
                    grant_log.push_back(p);
                    @(posedge clock); #1 req_l = 1'b0;
                    @(posedge clock); #1 val_l = jobs[cur].w0;
                    @(posedge clock); #1 val_l = jobs[cur].w1;
                end else begin
                    req_l = 1'b0;
                end
                cur++;
                done_jobs++;
            end
        end
    end

    // Output monitor: scoreboard pops, one-hot ack and hold stability.
    logic        held = 1'b0;
    logic [31:0] h_pt;
    logic [15:0] h_idx;
    logic [1:0]  h_src;
    exp_t        me;

    always @(negedge clock) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (ack != 4'b0000) check("ack_onehot", 64'($countones(ack)), 64'd1);
            if (held && valid) check("hold_stable", 64'({point, mem_idx, src}), 64'({h_pt, h_idx, h_src}));
            if (valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_point", 64'(point), 64'hDEAD_0000_0000);
                end else begin
                    me = exp_q.pop_front();
                    check("point", 64'(point), 64'(me.pt));
                    check("mem_index", 64'(mem_idx), 64'(me.idx));
                    check("src", 64'(src), 64'(me.src));
                end
            end
            held  = valid && !i_ready;
            h_pt  = point;
            h_idx = mem_idx;
            h_src = src;
        end
    end

    task automatic do_reset();
        @(posedge clock); #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_point", 64'(point), 64'd0);
        check("rst_mem_index", 64'(mem_idx), 64'd0);
        check("rst_src", 64'(src), 64'd0);
        @(posedge clock); #1 reset_n = 1'b1;
    endtask

    task automatic wait_ack(output logic [3:0] a);
        int n = 0;
        @(negedge clock);
        while (ack == 4'b0000 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("ack_seen", 64'(n < 100), 64'd1);
        a = ack;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || valid || done_jobs != released) && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("drain", 64'(n < 500), 64'd1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a;
        int n, acks, c0, ack_c, val_c;

        // Test 1: single request from partitioner 2.
        do_reset();
        i_ready = 1'b1;
        add_job(2, 16'h0012, 16'hAAAA, 16'h5555, 32'h5555AAAA);
        release_jobs();
        wait_ack(a);
        check("t1_ack", 64'(a), 64'b0100);
        @(negedge clock);
        check("t1_ack_pulse", 64'(ack), 64'd0);
        n = 1;
        while (!valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t1_latency", 64'(n), 64'd4);
        check("t1_src", 64'(src), 64'd2);
        drain();

        // Test 2: all four request, round-robin order from reset.
        do_reset();
        grant_log.delete();
        add_job(0, 16'h0100, 16'h0A00, 16'h0B00, 32'h0B000A00);
        add_job(1, 16'h0101, 16'h1A01, 16'h1B01, 32'h1B011A01);
        add_job(2, 16'h0102, 16'h2A02, 16'h2B02, 32'h2B022A02);
        add_job(3, 16'h0103, 16'h3A03, 16'h3B03, 32'h3B033A03);
        add_job(0, 16'h0104, 16'h0A04, 16'h0B04, 32'h0B040A04);
        release_jobs();
        drain();
        check("t2_grants", 64'(grant_log.size()), 64'd5);
        if (grant_log.size() == 5) begin
            check("t2_g0", 64'(grant_log[0]), 64'd0);
            check("t2_g1", 64'(grant_log[1]), 64'd1);
            check("t2_g2", 64'(grant_log[2]), 64'd2);
            check("t2_g3", 64'(grant_log[3]), 64'd3);
            check("t2_g4", 64'(grant_log[4]), 64'd0);
        end

        // Test 3: back-pressure, second point waits in HOLD, no third grant.
        i_ready = 1'b0;
        add_job(1, 16'h0201, 16'hC001, 16'hD001, 32'hD001C001);
        add_job(2, 16'h0202, 16'hC002, 16'hD002, 32'hD002C002);
        add_job(3, 16'h0203, 16'hC003, 16'hD003, 32'hD003C003);
        release_jobs();
        acks = 0;
        repeat (40) begin
            @(negedge clock);
            if (ack != 4'b0000) acks++;
        end
        check("t3_acks", 64'(acks), 64'd2);
        check("t3_buf_point", 64'(point), 64'h0000_0000_D001_C001);
        @(posedge clock); #1 i_ready = 1'b1;
        @(negedge clock);
        check("t3_valid_p1", 64'(valid), 64'd1);
        check("t3_point_p1", 64'(point), 64'h0000_0000_D001_C001);
        @(negedge clock);
        check("t3_valid_p2", 64'(valid), 64'd1);
        check("t3_point_p2", 64'(point), 64'h0000_0000_D002_C002);
        drain();

        // Test 4: reset during COLLECT after word 0.
        do_reset();
        add_job(0, 16'h0400, 16'h1111, 16'h2222, 32'h22221111);
        release_jobs();
        wait_ack(a);
        @(posedge clock);
        @(posedge clock);
        @(posedge clock); #1 reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("t4_valid", 64'(valid), 64'd0);
        check("t4_ack", 64'(ack), 64'd0);
        exp_q.delete();
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (3) @(negedge clock);
        add_job(1, 16'h0444, 16'h3333, 16'h4444, 32'h44443333);
        release_jobs();
        drain();

        // Test 5: single partitioner, DIMENSION=1, PRECISION=32.
        @(posedge clock); #1;
        val1 = 32'hDEADBEEF;
        idx1 = 16'h0077;
        req1 = 1'b1;
        c0 = cyc;
        ack_c = -1;
        val_c = -1;
        n = 0;
        while (n < 20 && val_c < 0) begin
            @(negedge clock);
            n++;
            if (ack1 && ack_c < 0) begin
                ack_c = cyc - c0;
                req1 = 1'b0;
            end
            if (valid1) val_c = cyc - c0;
        end
        check("t5_ack_cycle", 64'(ack_c), 64'd1);
        check("t5_valid_cycle", 64'(val_c), 64'd4);
        check("t5_point", 64'(point1), 64'h0000_0000_DEAD_BEEF);
        check("t5_mem_index", 64'(midx1), 64'h0077);
        check("t5_src", 64'(src1), 64'd0);
        val1 = 32'hCAFEF00D;
        idx1 = 16'h0088;
        @(posedge clock); #1 req1 = 1'b1;
        n = 0;
        while (!ack1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t5_ack2", 64'(ack1), 64'd1);
        req1 = 1'b0;
        repeat (8) @(negedge clock);
        check("t5_hold_valid", 64'(valid1), 64'd1);
        check("t5_hold_point", 64'(point1), 64'h0000_0000_DEAD_BEEF);
        @(posedge clock); #1 ready1 = 1'b1;
        @(posedge clock); #1;
        check("t5_swap_valid", 64'(valid1), 64'd1);
        check("t5_swap_point", 64'(point1), 64'h0000_0000_CAFE_F00D);
        check("t5_swap_index", 64'(midx1), 64'h0088);
        @(posedge clock); #1;
        check("t5_drained", 64'(valid1), 64'd0);
        ready1 = 1'b0;

`ifdef REDUCE_COLLECTOR_PERF_EN
        // Test 6: 10 points with exactly 3 HOLD cycles.
        do_reset();
        i_ready = 1'b0;
        add_job(0, 16'h0600, 16'h6A00, 16'h6B00, 32'h6B006A00);
        release_jobs();
        n = 0;
        while (!valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("t6_first_valid", 64'(valid), 64'd1);
        add_job(1, 16'h0601, 16'h6A01, 16'h6B01, 32'h6B016A01);
        release_jobs();
        wait_ack(a);
        repeat (6) @(posedge clock);
        #1 i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            add_job(i % 4, 16'(16'h0610 + i), 16'(16'h7000 + i), 16'(16'h7100 + i),
                    {16'(16'h7100 + i), 16'(16'h7000 + i)});
        end
        release_jobs();
        drain();
        check("t6_points_received", 64'(pts), 64'd10);
        check("t6_hold_cycles", 64'(holds), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
